// File: rtl/mod_241_stream_reducer.sv
// Streaming front end for the 400-bit mod-241 reducer (RNS channel 241).
// Collects 25 little-endian 16-bit beats into an operand register, reduces
// the operand through x_400_mod_241 and presents the 8-bit residue on a
// valid/ready output. One operand is in flight at a time.

// Combinational 400-bit mod-241 reducer.
// The operand is split into 50 bytes; byte i carries weight 256^i, and
// 256 = 15 (mod 241), so each byte is scaled by 15^i mod 241 and summed.
// The weighted sum fits in 22 bits and gets one final constant modulo.
module x_400_mod_241 (
  input  logic [399:0] i_x,
  output logic [7:0]   o_r
);

  // Weight of byte idx: 15^idx mod 241, elaborated as a constant per byte.
  function automatic logic [7:0] byte_weight(input int idx);
    logic [15:0] w;
    w = 16'd1;
    for (int j = 0; j < idx; j++) begin
      w = (w * 16'd15) % 16'd241;
    end
    return w[7:0];
  endfunction

  logic [21:0] w_acc;

  // Sum of every byte times its folded weight (max 50*255*240 < 2^22).
  always_comb begin
    w_acc = '0;
    for (int i = 0; i < 50; i++) begin
      w_acc = w_acc + (22'(i_x[8*i +: 8]) * 22'(byte_weight(i)));
    end
  end

  assign o_r = 8'(w_acc % 22'd241);

endmodule

module mod_241_stream_reducer #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_res,
  output logic              out_err
);

  localparam int OP_W      = 400;
  localparam int NUM_BEATS = OP_W / WORD_W;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    REDUCE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t          r_state;
  logic [OP_W-1:0] r_operand;
  logic [4:0]      r_beat_cnt;
  logic            r_err;
  logic [7:0]      r_res;
  logic            r_out_err;

  logic [7:0]      w_res;
  logic [8:0]      w_slice_base;
  logic            w_final_beat;

  assign w_slice_base = 9'(r_beat_cnt) * 9'(WORD_W);
  assign w_final_beat = (r_beat_cnt == 5'(NUM_BEATS - 1));

  x_400_mod_241 u_reducer (
    .i_x (r_operand),
    .o_r (w_res)
  );

  // Load / reduce / hold sequencing; the operand is zeroed between frames so
  // beats never driven by a short frame read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= LOAD;
      r_operand  <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
      r_res      <= 8'h00;
      r_out_err  <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (in_valid) begin
            r_operand[w_slice_base +: WORD_W] <= in_data;
            r_beat_cnt                        <= r_beat_cnt + 5'd1;
            if (in_last || w_final_beat) begin
              // Clean only when in_last lands exactly on the final beat.
              r_err   <= !(in_last && w_final_beat);
              r_state <= REDUCE;
            end
          end
        end
        REDUCE: begin
          r_res     <= w_res;
          r_out_err <= r_err;
          r_state   <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            r_operand  <= '0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
            r_state    <= LOAD;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  // Handshake flags decode straight from the state register, so in_ready
  // follows rst asynchronously and never overlaps out_valid.
  assign in_ready  = (r_state == LOAD);
  assign out_valid = (r_state == HOLD);
  assign out_res   = r_res;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_mod_241_stream_reducer.sv
// Bench for mod_241_stream_reducer: frames are driven beat by beat, the
// expected residue/error is queued when a frame is sent and checked when the
// DUT presents it.
module tb_mod_241_stream_reducer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_res;
  logic        out_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct packed {
    logic [7:0] res;
    logic       err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] beats[25];

  mod_241_stream_reducer #(.WORD_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Reference: Horner evaluation from the most significant beat down;
  // beats at index >= nb were never sent and count as zero.
  function automatic int model_mod(input int nb);
    int r;
    int v;
    r = 0;
    for (int k = 24; k >= 0; k--) begin
      v = (k < nb) ? int'(beats[k]) : 0;
      r = (r * 65536 + v) % 241;
    end
    return r;
  endfunction

  task automatic clear_beats();
    for (int k = 0; k < 25; k++) beats[k] = 16'h0000;
  endtask

  task automatic set_value(input int v);
    clear_beats();
    beats[0] = v[15:0];
    beats[1] = v[31:16];
  endtask

  // Drive nb beats; in_last on the final one when with_last. last_edge is
  // the cycle count just after the edge that accepted the final beat.
  task automatic send_frame(input int nb, input bit with_last, input bit gaps,
                            input bit push, output int last_edge);
    exp_t e;
    int   waitc;
    bit   acc;
    if (push) begin
      e.res = 8'(model_mod(nb));
      e.err = !(with_last && nb == 25);
      sb.push_back(e);
    end
    for (int k = 0; k < nb; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      in_valid = 1'b1;
      in_data  = beats[k];
      in_last  = with_last && (k == nb - 1);
      waitc = 0;
      do begin
        acc = in_ready;
        @(posedge clk); #1;
        waitc++;
      end while (!acc && waitc < 50);
      if (!acc) begin
        n_tests++; n_fail++;
        $display("FAIL beat_accept: beat %0d in_ready got 0, required 1 within 50 cycles", k);
      end
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    last_edge = cyc;
  endtask

  // Wait for the residue, hold off for stall cycles, then handshake.
  task automatic get_output(input int stall, input int last_edge, input bit chk_lat,
                            input string tag);
    int         waitc;
    exp_t       e;
    logic [7:0] r0;
    logic       e0;
    waitc = 0;
    while (out_valid !== 1'b1 && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s out_valid_timeout: got %b, required 1", tag, out_valid);
      return;
    end
    if (chk_lat) begin
      // Final beat accepted at edge t, residue registered at edge t+1.
      n_tests++;
      if (cyc - last_edge != 1) begin
        n_fail++;
        $display("FAIL %s latency: got %0d edges after accept, required 1", tag, cyc - last_edge);
      end
    end
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s in_ready_in_hold: got %b, required 0", tag, in_ready);
    end
    r0 = out_res;
    e0 = out_err;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b1 || out_res !== r0 || out_err !== e0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL %s hold_stable c%0d: got v=%b r=%0d e=%b rdy=%b, required v=1 r=%0d e=%b rdy=0",
                 tag, s, out_valid, out_res, out_err, in_ready, r0, e0);
      end
    end
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard: got residue %0d with empty queue, required none", tag, out_res);
    end else begin
      e = sb.pop_front();
      if (out_res !== e.res) begin
        n_fail++;
        $display("FAIL %s out_res: got %0d, required %0d", tag, out_res, e.res);
      end
      n_tests++;
      if (out_err !== e.err) begin
        n_fail++;
        $display("FAIL %s out_err: got %b, required %b", tag, out_err, e.err);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s post_handshake: got v=%b rdy=%b, required v=0 rdy=1", tag, out_valid, in_ready);
    end
  endtask

  task automatic check_reset_values(input string tag);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_res !== 8'h00 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s reset_values: got rdy=%b v=%b r=%0d e=%b, required rdy=1 v=0 r=0 e=0",
               tag, in_ready, out_valid, out_res, out_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0000; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_boundary();
    int vals[4] = '{0, 240, 241, 482};
    int le;
    foreach (vals[i]) begin
      set_value(vals[i]);
      send_frame(25, 1'b1, 1'b0, 1'b1, le);
      get_output(0, le, 1'b1, $sformatf("boundary_%0d", vals[i]));
    end
  endtask

  task automatic test_full_width();
    int le;
    for (int k = 0; k < 25; k++) beats[k] = 16'hFFFF;
    send_frame(25, 1'b1, 1'b0, 1'b1, le);
    get_output(0, le, 1'b1, "all_ones");
    clear_beats();
    beats[24] = 16'h8000;  // X = 2^399
    send_frame(25, 1'b1, 1'b0, 1'b1, le);
    get_output(0, le, 1'b1, "pow2_399");
  endtask

  task automatic test_early_last();
    int le;
    clear_beats();
    beats[0] = 16'h0001; beats[1] = 16'h0000; beats[2] = 16'h0001;
    send_frame(3, 1'b1, 1'b0, 1'b1, le);
    get_output(0, le, 1'b1, "early_last");
    set_value(5);
    send_frame(25, 1'b1, 1'b0, 1'b1, le);
    get_output(0, le, 1'b1, "after_early");
  endtask

  task automatic test_stall_backpressure();
    int le;
    for (int k = 0; k < 25; k++) beats[k] = 16'($urandom);
    send_frame(25, 1'b1, 1'b0, 1'b1, le);
    get_output(0, le, 1'b1, "gapless");
    send_frame(25, 1'b1, 1'b1, 1'b1, le);
    get_output(7, le, 1'b1, "gapped_bp7");
  endtask

  task automatic test_missing_last();
    int le;
    set_value(241);
    send_frame(25, 1'b0, 1'b0, 1'b1, le);
    // A 26th beat waits on the bus; in_ready must stay low until handshake.
    in_valid = 1'b1;
    in_data  = 16'h1234;
    get_output(3, le, 1'b1, "missing_last");
  endtask

  task automatic test_reset_mid_load();
    int le;
    for (int k = 0; k < 25; k++) beats[k] = 16'($urandom);
    send_frame(10, 1'b0, 1'b0, 1'b0, le);
    #2 rst = 1'b1;
    #1 check_reset_values("rst_mid_load");
    #1 rst = 1'b0;
    @(posedge clk); #1;
    set_value(240);
    send_frame(25, 1'b1, 1'b0, 1'b1, le);
    get_output(0, le, 1'b1, "after_rst_load");
  endtask

  task automatic test_reset_in_hold();
    int le;
    int waitc;
    set_value(7);
    send_frame(25, 1'b1, 1'b0, 1'b0, le);
    waitc = 0;
    while (out_valid !== 1'b1 && waitc < 50) begin
      @(posedge clk); #1;
      waitc++;
    end
    n_tests++;
    if (out_valid !== 1'b1 || out_res !== 8'd7) begin
      n_fail++;
      $display("FAIL rst_hold_pre: got v=%b r=%0d, required v=1 r=7", out_valid, out_res);
    end
    #2 rst = 1'b1;
    #1 check_reset_values("rst_in_hold");
    #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_hold_dropped: got out_valid %b, required 0", out_valid);
      end
    end
    out_ready = 1'b0;
    set_value(5);
    send_frame(25, 1'b1, 1'b0, 1'b1, le);
    get_output(0, le, 1'b1, "after_rst_hold");
  endtask

  initial begin
    test_reset();
    test_boundary();
    test_full_width();
    test_early_last();
    test_stall_backpressure();
    test_missing_last();
    test_reset_mid_load();
    test_reset_in_hold();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
